uart_rx: RTL and testbench

Serial receiver for the game UART link, downstream of the UART transmitter on the same frame format.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (parity = XOR of the 8 data bits), 1 stop bit (1).
- Recovers each byte from the asynchronous line and presents it with a one-cycle valid strobe plus parity and framing error flags to the game logic.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8E1 serial receiver (start, 8 data LSB first, even parity, stop) with valid strobe and error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre (adds one cycle of latency).
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_DELAY = 1;
`else
    localparam int MAJ_DELAY = 0;
`endif

    // Only START carries the majority offset; later states inherit it through the delayed entry.
    localparam logic [CNT_W-1:0] HALF_PT = CNT_W'(CLKS_PER_BIT / 2 - 1 + MAJ_DELAY);
    localparam logic [CNT_W-1:0] FULL_PT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic             bit_val;
    logic             sample_pt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             parity_bit;

    // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial_in;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1;
    logic rx_d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = (rx_d1 & rx_d2) | (rx_d1 & rx_s) | (rx_d2 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign sample_pt = (state == START) ? (cnt == HALF_PT) : (cnt == FULL_PT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (sample_pt) state_next = bit_val ? IDLE : DATA;
            DATA:    if (sample_pt && bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  if (sample_pt) state_next = STOP;
            STOP:    if (sample_pt) state_next = bit_val ? IDLE : BREAK;
            BREAK:   if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state != IDLE);
    end

    // The bit counter restarts on every state change and after every sample, so DATA bits stay one period apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            rx_data_out <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state_next != state || sample_pt) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            case (state)
                START: begin
                    if (sample_pt) bit_cnt <= '0;
                end
                DATA: begin
                    if (sample_pt) begin
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    if (sample_pt) parity_bit <= bit_val;
                end
                STOP: begin
                    if (sample_pt) begin
                        rx_data_out <= shreg;
                        parity_err  <= (^shreg) ^ parity_bit;
                        frame_err   <= ~bit_val;
                        rx_valid    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a byte-level reference model of the receiver.
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int EXP_LAT = 10 * CPB + CPB / 2 + 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_line;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    rec_t got_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_serial_in (rx_line),
        .rx_data_out  (rx_data_out),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with the strobe high is logged, so a stretched strobe shows up as an extra record.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rec_t r;
            r.data = rx_data_out;
            r.perr = parity_err;
            r.ferr = frame_err;
            r.cyc  = cyc;
            got_q.push_back(r);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int count_ones(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic logic model_perr(input logic [7:0] d, input logic par);
        return ((count_ones(d) % 2) != int'(par));
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop_bit,
                                 output int fall_cyc);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop_bit);
    endtask

    task automatic get_record(input string tag, output rec_t r);
        int waited = 0;
        r.data = '0;
        r.perr = 1'b0;
        r.ferr = 1'b0;
        r.cyc  = 0;
        while (got_q.size() == 0 && waited < 4 * CPB) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_strobe"}, int'(got_q.size() != 0), 1);
        if (got_q.size() != 0) r = got_q.pop_front();
        checkOutput({tag, "_single"}, got_q.size(), 0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic par,
                               input logic stop_bit, output rec_t r);
        get_record(tag, r);
        checkOutput({tag, "_data"}, int'(r.data), int'(d));
        checkOutput({tag, "_perr"}, int'(r.perr), int'(model_perr(d, par)));
        checkOutput({tag, "_ferr"}, int'(r.ferr), int'(!stop_bit));
    endtask

    initial begin
        rec_t r;
        rec_t r2;
        int   fall;
        int   fall2;
        int   lat;
        logic saw_busy;
        int   drop_k;
        logic [7:0] d;
        logic par;
        logic stop_bit;

        reset   = 1'b1;
        rx_line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data",  int'(rx_data_out), 0);
        checkOutput("rst_valid", int'(rx_valid), 0);
        checkOutput("rst_busy",  int'(rx_busy), 0);
        checkOutput("rst_perr",  int'(parity_err), 0);
        checkOutput("rst_ferr",  int'(frame_err), 0);
        reset = 1'b0;
        idle_cycles(2 * CPB);

        // Clean frame with latency measurement.
        applyStimulus(8'hA5, 1'b0, 1'b1, fall);
        check_frame("t1", 8'hA5, 1'b0, 1'b1, r);
        lat = r.cyc - fall;
        checkOutput("t1_latency", int'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1);
        idle_cycles(CPB);
        checkOutput("t1_hold", int'(rx_data_out), 8'hA5);

        applyStimulus(8'h01, 1'b0, 1'b1, fall);
        check_frame("t2", 8'h01, 1'b0, 1'b1, r);
        idle_cycles(CPB);

        // Stop bit low followed by a long break, then a clean frame.
        applyStimulus(8'h3C, 1'b0, 1'b0, fall);
        check_frame("t3a", 8'h3C, 1'b0, 1'b0, r);
        idle_cycles(20 * CPB);
        checkOutput("t3_busy_break", int'(rx_busy), 1);
        checkOutput("t3_no_extra", got_q.size(), 0);
        rx_line = 1'b1;
        idle_cycles(CPB);
        checkOutput("t3_busy_released", int'(rx_busy), 0);
        applyStimulus(8'h55, 1'b0, 1'b1, fall);
        check_frame("t3b", 8'h55, 1'b0, 1'b1, r);
        idle_cycles(CPB);

        // Four-cycle glitch must be rejected at the half-bit check.
        saw_busy = 1'b0;
        drop_k   = -1;
        rx_line  = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) rx_line = 1'b1;
            if (rx_busy === 1'b1) saw_busy = 1'b1;
            else if (saw_busy && drop_k < 0) drop_k = k;
        end
        checkOutput("t4_busy_seen", int'(saw_busy), 1);
        checkOutput("t4_busy_drop", int'(drop_k > 0), 1);
        idle_cycles(2 * CPB);
        checkOutput("t4_no_valid", got_q.size(), 0);

        // Reset in the middle of data bit 4.
        rx_line = 1'b0;
        repeat (5) drive_bit(1'b0);
        rx_line = 1'b1;
        idle_cycles(CPB / 2);
        checkOutput("t5_busy_pre", int'(rx_busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_rst_data",  int'(rx_data_out), 0);
        checkOutput("t5_rst_valid", int'(rx_valid), 0);
        checkOutput("t5_rst_busy",  int'(rx_busy), 0);
        checkOutput("t5_rst_perr",  int'(parity_err), 0);
        checkOutput("t5_rst_ferr",  int'(frame_err), 0);
        reset = 1'b0;
        idle_cycles(2 * CPB);
        checkOutput("t5_no_valid", got_q.size(), 0);
        applyStimulus(8'hFF, 1'b0, 1'b1, fall);
        check_frame("t5", 8'hFF, 1'b0, 1'b1, r);
        idle_cycles(CPB);

        // Back-to-back frames with no idle gap.
        applyStimulus(8'h00, 1'b0, 1'b1, fall);
        check_frame("t6a", 8'h00, 1'b0, 1'b1, r);
        applyStimulus(8'hFF, 1'b0, 1'b1, fall2);
        check_frame("t6b", 8'hFF, 1'b0, 1'b1, r2);
        checkOutput("t6_spacing", r2.cyc - r.cyc, 11 * CPB);
        idle_cycles(CPB);

        // Random frames: mostly good parity and stop, some corrupted, random idle gaps.
        for (int i = 0; i < 16; i++) begin
            d        = 8'($urandom);
            par      = 1'((count_ones(d) % 2) != 0);
            if ($urandom_range(0, 3) == 0) par = ~par;
            stop_bit = ($urandom_range(0, 4) != 0);
            applyStimulus(d, par, stop_bit, fall);
            check_frame($sformatf("rnd%0d", i), d, par, stop_bit, r);
            if (!stop_bit) begin
                rx_line = 1'b1;
                idle_cycles(CPB);
            end
            idle_cycles(int'($urandom_range(0, 3 * CPB)));
        end

        idle_cycles(2 * CPB);
        checkOutput("end_no_extra", got_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
